// File: rtl/data_ram_bx.sv
// Byte-addressed 32-bit data RAM with sized loads/stores, registered responses,
// misalignment faults and a one-word-per-cycle hardware clear after reset.
module data_ram_bx #(
  parameter int unsigned ADDR_W = 12,
  parameter bit          TRACE  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       pc,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {StClear, StRun} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              ready_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic              rsp_fault_q;
  logic [31:0]       rsp_rdata_q;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic [31:0]       rd_word;
  logic              fault;
  logic [3:0]        be;
  logic [31:0]       wdat;
  logic [31:0]       merged;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       ld_ext;

  assign accept  = req_valid && ready_q && (state_q == StRun);
  assign idx     = req_addr[ADDR_W+1:2];
  assign off     = req_addr[1:0];
  assign rd_word = mem[idx];

  always_comb begin
    fault = 1'b1;
    be    = 4'b0000;
    wdat  = req_wdata;
    unique case (req_size)
      2'b00: begin
        fault = 1'b0;
        be    = 4'(4'b0001 << off);
        wdat  = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        fault = off[0];
        be    = 4'(4'b0011 << off);
        wdat  = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        fault = (off != 2'b00);
        be    = 4'b1111;
      end
      default: fault = 1'b1;
    endcase
  end

  // Read-modify-write merge: only the enabled lanes take store data.
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdat[8*i +: 8];
    end
  end

  always_comb begin
    byte_sel = 8'(rd_word >> {off, 3'b000});
    half_sel = 16'(rd_word >> {off[1], 4'b0000});
    ld_ext   = '0;
    unique case (req_size)
      2'b00:   ld_ext = req_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   ld_ext = req_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      2'b10:   ld_ext = rd_word;
      default: ld_ext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StClear) begin
        mem[clr_cnt_q] <= '0;
      end else if (accept && req_we && !fault) begin
        mem[idx] <= merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StClear;
      clr_cnt_q   <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_cnt_q   <= clr_cnt_q + 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_fault_q <= 1'b0;
          rsp_rdata_q <= '0;
          if (clr_cnt_q == '1) begin
            state_q <= StRun;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        StRun: begin
          rsp_valid_q <= accept;
          rsp_fault_q <= accept && fault;
          rsp_rdata_q <= (accept && !req_we && !fault) ? ld_ext : '0;
        end
        default: state_q <= StClear;
      endcase
    end
  end

  if (TRACE) begin : g_trace
    always_ff @(posedge clk) begin
      if (!rst && accept && req_we && !fault) begin
        $display("[data_ram_bx] t=%0t pc=%08h addr=%h data=%08h", $time, pc, req_addr, merged);
      end
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
